// File: rtl/fifo_pop_ctrl.sv
// Pops an upstream FIFO into a 2-entry skid buffer and presents words as valid/ready.
// Latency: 1 cycle from pop to out_data. Backpressure: stall fills the skid entry, then pop stops while FULL.
// Optional drain counter enabled by macro FIFO_POP_CTRL_COUNT_EN.
module fifo_pop_ctrl #(
    parameter int WIDTH  = 8,
    parameter int CNTWID = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [WIDTH-1:0]  fifo_data,
    output logic              fifo_pop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data
`ifdef FIFO_POP_CTRL_COUNT_EN
    ,
    output logic [CNTWID-1:0] drain_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic             hs;

    if (WIDTH < 1 || CNTWID < 1) begin : g_param_check
        $error("fifo_pop_ctrl: WIDTH and CNTWID must be at least 1");
    end

    // Pop depends only on registered occupancy, never on out_ready.
    assign fifo_pop = !rst && !fifo_empty && (state != FULL);
    assign hs       = out_valid && out_ready;
    assign out_data = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            head      <= '0;
            skid      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (fifo_pop) begin
                        head      <= fifo_data;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    case ({fifo_pop, hs})
                        2'b11: head <= fifo_data;
                        2'b10: begin
                            skid  <= fifo_data;
                            state <= FULL;
                        end
                        2'b01: begin
                            state     <= EMPTY;
                            out_valid <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (hs) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_POP_CTRL_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_count <= '0;
        end else if (hs) begin
            drain_count <= drain_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Directed plus randomized bench for fifo_pop_ctrl against a queue-based reference model.
module tb_fifo_pop_ctrl;
    localparam int WIDTH  = 8;
    localparam int CNTWID = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef FIFO_POP_CTRL_COUNT_EN
    logic [CNTWID-1:0] drain_count;
`endif

    fifo_pop_ctrl #(.WIDTH(WIDTH), .CNTWID(CNTWID)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef FIFO_POP_CTRL_COUNT_EN
        ,
        .drain_count(drain_count)
`endif
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] up_q[$];   // upstream FIFO contents
    logic [WIDTH-1:0] mb[$];     // words held by the controller, oldest first
    int               checks    = 0;
    int               errors    = 0;
    int               obs_pops  = 0;
    int               exp_cnt   = 0;
    bit               data_zero = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_up();
        fifo_empty = (up_q.size() == 0);
        fifo_data  = (up_q.size() != 0) ? up_q[0] : WIDTH'($urandom);
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        up_q.push_back(v);
        drive_up();
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cycle();
        logic ep, ev;
        #1;
        ep = !rst && (up_q.size() != 0) && (mb.size() < 2);
        ev = (mb.size() != 0);
        check("fifo_pop", {31'd0, fifo_pop}, {31'd0, ep});
        check("out_valid", {31'd0, out_valid}, {31'd0, ev});
        if (ev) check("out_data", 32'(out_data), 32'(mb[0]));
        else if (data_zero) check("out_data_rst", 32'(out_data), 32'd0);
`ifdef FIFO_POP_CTRL_COUNT_EN
        check("drain_count", 32'(drain_count), 32'(exp_cnt));
`endif
        if (fifo_pop === 1'b1) obs_pops++;
        @(posedge clk);
        if (rst) begin
            mb.delete();
            data_zero = 1'b1;
            exp_cnt   = 0;
        end else begin
            if (ev && out_ready) begin
                void'(mb.pop_front());
                exp_cnt = (exp_cnt + 1) % (1 << CNTWID);
            end
            if (ep) begin
                mb.push_back(up_q.pop_front());
                data_zero = 1'b0;
            end
        end
        @(negedge clk);
        drive_up();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst        = 1'b1;
        out_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held two cycles with a non-empty upstream
        out_ready = 1'b1;
        push(8'h55);
        cycles(2);
        up_q.delete();
        rst = 1'b0;
        drive_up();
        cycles(1);

        // Streaming
        out_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        obs_pops = 0;
        cycles(5);
        check("stream_pops", 32'(obs_pops), 32'd3);

        // Backpressure fills the skid, then drains in order
        out_ready = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3);
        obs_pops = 0;
        cycles(4);
        check("bp_pops", 32'(obs_pops), 32'd2);
        check("bp_head", 32'(out_data), 32'h0000_00A1);
        out_ready = 1'b1;
        cycles(5);
        check("bp_drained_valid", {31'd0, out_valid}, 32'd0);

        // Upstream goes empty while holding one word
        out_ready = 1'b0;
        push(8'h5A);
        cycles(2);
        out_ready = 1'b1;
        cycles(2);
        check("empty_up_valid", {31'd0, out_valid}, 32'd0);

        // Reset while FULL
        out_ready = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3);
        cycles(3);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        cycles(4);

        // Counter wrap: 17 handshakes on a 4-bit counter
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) up_q.push_back(WIDTH'(i + 8'h60));
        drive_up();
        cycles(20);
`ifdef FIFO_POP_CTRL_COUNT_EN
        check("cnt_wrap", 32'(drain_count), 32'd1);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0 && up_q.size() < 6) up_q.push_back(WIDTH'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 59) == 0);
            drive_up();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
